// File: rtl/multiplier_host_if.sv
// rtl/multiplier_host_if.sv - request/response handshake bundle for the multiplier bus host
interface multiplier_host_if #(
   parameter int n = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [n-1:0]     req_m;
   logic [n-1:0]     req_q;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [2*n-1:0]   rsp_product;
   logic             rsp_error;

   modport master (
      output req_valid, req_m, req_q, rsp_ready,
      input  req_ready, rsp_valid, rsp_product, rsp_error
   );

   modport slave (
      input  req_valid, req_m, req_q, rsp_ready,
      output req_ready, rsp_valid, rsp_product, rsp_error
   );
endinterface

// File: rtl/multiplier_host.sv
// rtl/multiplier_host.sv - sequences write M/Q, start, wait, read lo/hi on the shared-bus multiplier
// Optional ready-wait timeout enabled by defining MULT_HOST_TIMEOUT_EN.
module multiplier_host #(
   parameter int n              = 8,
   parameter int freq           = 3330000,
   parameter int START_CYCLES   = freq / 500,
   parameter int SETUP_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = freq / 100
) (
   input  logic             osc_clk,
   input  logic             nreset,
   multiplier_host_if.slave host,
   output logic [1:0]       func,
   output logic             oe,
   output logic             startPB,
   input  logic             ready,
   inout  wire  [n-1:0]     data
);

   localparam int PH_MAX = (START_CYCLES > SETUP_CYCLES) ? START_CYCLES : SETUP_CYCLES;
   localparam int PW     = $clog2(PH_MAX + 1);
   localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYCLES - 1);
   localparam logic [PW-1:0] START_LAST = PW'(START_CYCLES - 1);

   localparam logic [1:0] F_WR_M = 2'b00;
   localparam logic [1:0] F_WR_Q = 2'b01;
   localparam logic [1:0] F_PARK = 2'b10;
   localparam logic [1:0] F_RD_HI = 2'b11;

   generate
      if (SETUP_CYCLES < 2 || START_CYCLES <= freq / 1000 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
         $error("multiplier_host: inconsistent timing parameters");
      end
   endgenerate

   typedef enum logic [3:0] {
      IDLE, WR_M, WR_Q, GAP, START, WAIT_LO, WAIT_HI, RD_LO, RD_HI, RESP
   } state_t;

   state_t          state;
   logic [PW-1:0]   ph_cnt;
   logic [n-1:0]    m_reg;
   logic [n-1:0]    q_reg;
   logic [2*n-1:0]  product;
   logic            req_rdy;
   logic            rsp_vld;
   logic            drive;

   // drive is only ever set in the write phases, where oe is held low
   assign data = drive ? ((func == F_WR_M) ? m_reg : q_reg) : {n{1'bz}};

   assign host.req_ready   = req_rdy;
   assign host.rsp_valid   = rsp_vld;
   assign host.rsp_product = product;

`ifdef MULT_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] to_cnt;
   logic          err;
   assign host.rsp_error = err;
`else
   assign host.rsp_error = 1'b0;
`endif

   always_ff @(posedge osc_clk or negedge nreset) begin
      if (!nreset) begin
         state   <= IDLE;
         ph_cnt  <= '0;
         m_reg   <= '0;
         q_reg   <= '0;
         product <= '0;
         req_rdy <= 1'b0;
         rsp_vld <= 1'b0;
         drive   <= 1'b0;
         func    <= F_PARK;
         oe      <= 1'b0;
         startPB <= 1'b1;
`ifdef MULT_HOST_TIMEOUT_EN
         to_cnt  <= '0;
         err     <= 1'b0;
`endif
      end else begin
`ifdef MULT_HOST_TIMEOUT_EN
         to_cnt <= '0;
`endif
         case (state)
            IDLE: begin
               req_rdy <= 1'b1;
               if (host.req_valid && req_rdy) begin
                  m_reg   <= host.req_m;
                  q_reg   <= host.req_q;
                  req_rdy <= 1'b0;
                  product <= '0;
`ifdef MULT_HOST_TIMEOUT_EN
                  err     <= 1'b0;
`endif
                  func    <= F_WR_M;
                  drive   <= 1'b1;
                  ph_cnt  <= '0;
                  state   <= WR_M;
               end
            end
            WR_M: begin
               if (ph_cnt == SETUP_LAST) begin
                  ph_cnt <= '0;
                  func   <= F_WR_Q;
                  state  <= WR_Q;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end
            WR_Q: begin
               if (ph_cnt == SETUP_LAST) begin
                  ph_cnt <= '0;
                  func   <= F_PARK;
                  drive  <= 1'b0;
                  state  <= GAP;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end
            GAP: begin
               startPB <= 1'b0;
               ph_cnt  <= '0;
               state   <= START;
            end
            START: begin
               if (ph_cnt == START_LAST) begin
                  startPB <= 1'b1;
                  ph_cnt  <= '0;
                  state   <= WAIT_LO;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end
            WAIT_LO: begin
               if (!ready) begin
                  state <= WAIT_HI;
               end
`ifdef MULT_HOST_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  err     <= 1'b1;
                  product <= '0;
                  rsp_vld <= 1'b1;
                  state   <= RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            WAIT_HI: begin
               if (ready) begin
                  oe     <= 1'b1;
                  func   <= F_PARK;
                  ph_cnt <= '0;
                  state  <= RD_LO;
               end
`ifdef MULT_HOST_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  err     <= 1'b1;
                  product <= '0;
                  rsp_vld <= 1'b1;
                  state   <= RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            RD_LO: begin
               if (ph_cnt == SETUP_LAST) begin
                  product[n-1:0] <= data;
                  func           <= F_RD_HI;
                  ph_cnt         <= '0;
                  state          <= RD_HI;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end
            RD_HI: begin
               if (ph_cnt == SETUP_LAST) begin
                  product[2*n-1:n] <= data;
                  oe               <= 1'b0;
                  func             <= F_PARK;
                  rsp_vld          <= 1'b1;
                  ph_cnt           <= '0;
                  state            <= RESP;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end
            RESP: begin
               // a new request waits for IDLE so req_ready is never high here
               if (host.rsp_ready) begin
                  rsp_vld <= 1'b0;
                  req_rdy <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier_host.sv
// tb/tb_multiplier_host.sv - randomized bench with a behavioural peripheral and product scoreboard
module tb_multiplier_host;
   localparam int N     = 8;
   localparam int START = 8;
   localparam int SETUP = 2;
   localparam int TMO   = 100;

   logic        osc_clk = 1'b0;
   logic        nreset  = 1'b0;
   logic [1:0]  func;
   logic        oe;
   logic        startPB;
   logic        ready;
   wire  [N-1:0] data;

   always #5 osc_clk = ~osc_clk;

   multiplier_host_if #(.n(N)) hif ();

   multiplier_host #(
      .n(N), .freq(4000), .START_CYCLES(START), .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .osc_clk(osc_clk), .nreset(nreset), .host(hif),
      .func(func), .oe(oe), .startPB(startPB), .ready(ready), .data(data)
   );

   int          checks   = 0;
   int          failures = 0;
   longint      cyc      = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  cur_m = 0, cur_q = 0;
   int          tok = 0;
   logic        stuck = 1'b0;

   always @(posedge osc_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // behavioural peripheral: latches M/Q, goes busy after a start pulse, serves product bytes
   logic [7:0]  pm = 0, pq = 0;
   logic [15:0] pprod = 0;
   logic [7:0]  per_val;
   assign per_val = (func == 2'b11) ? pprod[15:8] : pprod[7:0];
   assign data    = oe ? per_val : 8'bz;

   always @(negedge osc_clk) begin
      if (func == 2'b00) pm <= data;
      else if (func == 2'b01) pq <= data;
   end

   initial begin : periph
      ready = 1'b1;
      forever begin
         @(negedge startPB);
         @(posedge startPB);
         if (!stuck) begin
            repeat ($urandom_range(1, 3)) @(negedge osc_clk);
            ready = 1'b0;
            repeat ($urandom_range(4, 15)) @(negedge osc_clk);
            pprod = {8'h00, pm} * {8'h00, pq};
            ready = 1'b1;
         end
      end
   end

   // bus-rule monitor plus func-sequence capture per transaction
   int          run_m = 0, run_q = 0, low = 0, seen_tok = 0;
   logic [7:0]  seq = 0;
   logic [3:0]  nchg = 0;
   logic [1:0]  last = 2'b10;

   always @(negedge osc_clk) begin
      if (func == 2'b00) check("wr_m_data", data, cur_m);
      if (func == 2'b01) check("wr_q_data", data, cur_q);
      if (func[1] == 1'b0) check("wr_oe_low", oe, 0);
      if (oe) begin
         check("rd_func", func[1], 1);
         check("rd_bus", data, per_val);
      end
      if (func == 2'b00) run_m <= run_m + 1;
      else if (run_m != 0) begin check("wr_m_len", run_m, SETUP); run_m <= 0; end
      if (func == 2'b01) run_q <= run_q + 1;
      else if (run_q != 0) begin check("wr_q_len", run_q, SETUP); run_q <= 0; end
      if (!startPB) low <= low + 1;
      else if (low != 0) begin check("start_len", low, START); low <= 0; end
      if (tok != seen_tok) begin
         seen_tok <= tok; seq <= 0; nchg <= 0; last <= 2'b10;
      end else if (!hif.rsp_valid && func != last) begin
         seq <= {seq[5:0], func}; nchg <= nchg + 1'b1; last <= func;
      end
   end

   task automatic send(input logic [7:0] m, input logic [7:0] q);
      int t = 0;
      @(negedge osc_clk);
      hif.req_valid = 1'b1; hif.req_m = m; hif.req_q = q;
      cur_m = m; cur_q = q;
      while (!hif.req_ready && t < 1000) begin @(negedge osc_clk); t++; end
      check("req_accept", t < 1000, 1);
      tok++;
      exp_q.push_back(16'(int'(m) * int'(q)));
      @(negedge osc_clk);
      hif.req_valid = 1'b0; hif.req_m = 8'($urandom); hif.req_q = 8'($urandom);
   endtask

   task automatic get_rsp(input string tag);
      int t = 0;
      logic [15:0] e;
      while (!hif.rsp_valid && t < 1000) begin @(negedge osc_clk); t++; end
      check({tag, "_rsp_wait"}, t < 1000, 1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      check({tag, "_prod"}, hif.rsp_product, e);
      check({tag, "_err"}, hif.rsp_error, 0);
      check({tag, "_func_seq"}, {nchg, seq}, 12'h41B);
      hif.rsp_ready = 1'b1;
      @(negedge osc_clk);
      check({tag, "_drop"}, hif.rsp_valid, 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      logic [7:0]  a, b;
      logic [15:0] p0;
      int          bad, t, seen;
      longint      t0;
      hif.req_valid = 1'b0; hif.req_m = 0; hif.req_q = 0; hif.rsp_ready = 1'b1;
      repeat (3) @(negedge osc_clk);
      check("rst_req_ready", hif.req_ready, 0);
      check("rst_rsp_valid", hif.rsp_valid, 0);
      check("rst_product", hif.rsp_product, 0);
      check("rst_error", hif.rsp_error, 0);
      check("rst_func", func, 2'b10);
      check("rst_oe", oe, 0);
      check("rst_startpb", startPB, 1);
      nreset = 1'b1;
      @(negedge osc_clk);
      check("req_ready_after_rst", hif.req_ready, 1);

      send(8'd12, 8'd10);  get_rsp("basic");
      send(8'd255, 8'd255); get_rsp("full");
      send(8'd0, 8'd200);  get_rsp("zero");
      for (int i = 0; i < 6; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         send(a, b); get_rsp("rand");
      end

      hif.rsp_ready = 1'b0;
      send(8'd17, 8'd9);
      t = 0;
      while (!hif.rsp_valid && t < 1000) begin @(negedge osc_clk); t++; end
      check("bp_rsp_wait", t < 1000, 1);
      p0 = hif.rsp_product; bad = 0;
      repeat (50) begin
         @(negedge osc_clk);
         if (!hif.rsp_valid || hif.rsp_product != p0 || hif.req_ready) bad++;
      end
      check("bp_stable", bad, 0);
      check("bp_prod", p0, exp_q.pop_front());
      hif.rsp_ready = 1'b1; hif.req_valid = 1'b1; hif.req_m = 8'd3; hif.req_q = 8'd7;
      cur_m = 8'd3; cur_q = 8'd7; tok++;
      exp_q.push_back(16'd21);
      @(negedge osc_clk);
      check("b2b_drop", hif.rsp_valid, 0);
      check("b2b_ready_next", hif.req_ready, 1);
      @(negedge osc_clk);
      hif.req_valid = 1'b0;
      get_rsp("b2b");

      send(8'd9, 8'd9);
      t = 0;
      while (ready && t < 500) begin @(negedge osc_clk); t++; end
      check("mid_busy_wait", t < 500, 1);
      repeat (2) @(negedge osc_clk);
      nreset = 1'b0;
      #1;
      check("mid_func", func, 2'b10);
      check("mid_oe", oe, 0);
      check("mid_startpb", startPB, 1);
      check("mid_rsp_valid", hif.rsp_valid, 0);
      check("mid_req_ready", hif.req_ready, 0);
      void'(exp_q.pop_front());
      @(negedge osc_clk); nreset = 1'b1;
      @(negedge osc_clk);
      check("mid_ready_after", hif.req_ready, 1);
      repeat (20) @(negedge osc_clk);
      send(8'd5, 8'd5); get_rsp("after_rst");

      stuck = 1'b1;
      send(8'd11, 8'd13);
`ifdef MULT_HOST_TIMEOUT_EN
      t = 0;
      while (startPB && t < 200) begin @(negedge osc_clk); t++; end
      while (!startPB && t < 200) begin @(negedge osc_clk); t++; end
      t0 = cyc;
      while (!hif.rsp_valid && t < 600) begin @(negedge osc_clk); t++; end
      check("tmo_rsp_wait", t < 600, 1);
      check("tmo_cycles", 32'(cyc - t0), TMO);
      check("tmo_err", hif.rsp_error, 1);
      check("tmo_prod", hif.rsp_product, 0);
      void'(exp_q.pop_front());
      @(negedge osc_clk);
      check("tmo_drop", hif.rsp_valid, 0);
`else
      seen = 0;
      repeat (300) begin
         @(negedge osc_clk);
         if (hif.rsp_valid) seen = 1;
      end
      check("notmo_silent", seen, 0);
      nreset = 1'b0;
      @(negedge osc_clk); nreset = 1'b1;
      exp_q.delete();
`endif
      stuck = 1'b0;
      repeat (5) @(negedge osc_clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
